id_stage_pipe: RTL and testbench

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

---
 rtl/riscv_pkg.sv | 70 +++++++
 rtl/reg_file.sv | 40 ++++
 rtl/id_stage_pipe.sv | 124 ++++++++++++
 tb/tb_id_stage_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32/64 base opcodes, decode control encodings and immediate builder
// shared by the ID stage and its register file.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] ALU_LS    = 3'b000;
    localparam logic [2:0] ALU_BR    = 3'b001;
    localparam logic [2:0] ALU_R     = 3'b010;
    localparam logic [2:0] ALU_I     = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b100;
    localparam logic [2:0] ALU_AUIPC = 3'b101;
    localparam logic [2:0] ALU_JMP   = 3'b110;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       illegal;
        logic       use_rs1;
        logic       use_rs2;
        logic [1:0] memtoreg;
        logic [2:0] aluop;
        imm_fmt_t   fmt;
    } ctrl_t;

    function automatic ctrl_t decode(logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OPC_LUI:    begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.aluop = ALU_LUI; c.fmt = IMM_U; end
            OPC_AUIPC:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.aluop = ALU_AUIPC; c.fmt = IMM_U; end
            OPC_JAL:    begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.aluop = ALU_JMP; c.memtoreg = MTR_PC4; c.fmt = IMM_J; end
            OPC_JALR:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.aluop = ALU_JMP; c.memtoreg = MTR_PC4; c.fmt = IMM_I; c.use_rs1 = 1'b1; end
            OPC_BRANCH: begin c.branch = 1'b1; c.aluop = ALU_BR; c.fmt = IMM_B; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
            OPC_LOAD:   begin c.mem_read = 1'b1; c.reg_write = 1'b1; c.alu_src = 1'b1; c.memtoreg = MTR_MEM; c.aluop = ALU_LS; c.fmt = IMM_I; c.use_rs1 = 1'b1; end
            OPC_STORE:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.aluop = ALU_LS; c.fmt = IMM_S; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
            OPC_OP_IMM: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.aluop = ALU_I; c.fmt = IMM_I; c.use_rs1 = 1'b1; end
            OPC_OP:     begin c.reg_write = 1'b1; c.memtoreg = MTR_ALU; c.aluop = ALU_R; c.fmt = IMM_NONE; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
            default:    c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // 32-bit signed immediate; the caller sign-extends to XLEN
    function automatic logic [31:0] imm32(logic [31:0] i, imm_fmt_t f);
        return f == IMM_I ? {{20{i[31]}}, i[31:20]} :
               f == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
               f == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
               f == IMM_U ? {i[31:12], 12'b0} :
               f == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : 32'b0;
    endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: NREGS x XLEN register file, x0 hardwired to zero, two read ports,
// one write port, optional write-through forwarding to same-cycle reads.
module reg_file #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wen;

    function automatic logic in_range(logic [4:0] a);
        return a != 5'd0 && 32'(a) < NREGS;
    endfunction

    assign w_wen = i_we && in_range(i_waddr);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        else if (w_wen)
            r_regs[i_waddr[AW-1:0]] <= i_wdata;

    assign o_rdata1 = !in_range(i_raddr1) ? '0 :
                      (BYPASS != 0 && w_wen && i_waddr == i_raddr1) ? i_wdata : r_regs[i_raddr1[AW-1:0]];
    assign o_rdata2 = !in_range(i_raddr2) ? '0 :
                      (BYPASS != 0 && w_wen && i_waddr == i_raddr2) ? i_wdata : r_regs[i_raddr2[AW-1:0]];

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RISC-V decode stage with valid/ready handshake, load-use stall,
// flush, and a one-entry output register that tracks writebacks while held.
module id_stage_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc_in,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm_out,
    output logic [XLEN-1:0] pc_out,
    output logic [4:0]      rd_out,
    output logic [6:0]      opcode_out_d,
    output logic [2:0]      fn3_out_d,
    output logic            fn7_5,
    output logic            branch,
    output logic            mem_read,
    output logic            mem_write,
    output logic            alu_src,
    output logic            reg_write,
    output logic            illegal,
    output logic [1:0]      memtoreg,
    output logic [2:0]      aluop
);
    ctrl_t           w_ctrl;
    logic [4:0]      w_rs1_idx, w_rs2_idx;
    logic [XLEN-1:0] w_rs1_data, w_rs2_data, w_imm;
    logic            w_hazard, w_accept, w_hit1, w_hit2;
    logic [4:0]      r_rs1_idx, r_rs2_idx;

    assign w_ctrl = decode(instruction[6:0]);
    // Unused or out-of-range sources collapse to x0 so they never stall or track writes
    assign w_rs1_idx = (w_ctrl.use_rs1 && 32'(instruction[19:15]) < NREGS) ? instruction[19:15] : 5'd0;
    assign w_rs2_idx = (w_ctrl.use_rs2 && 32'(instruction[24:20]) < NREGS) ? instruction[24:20] : 5'd0;
    assign w_imm     = XLEN'(signed'(imm32(instruction, w_ctrl.fmt)));
    assign w_hazard  = ex_mem_read && ex_rd != 5'd0 && (ex_rd == w_rs1_idx || ex_rd == w_rs2_idx);
    assign in_ready  = reset && !flush && (!out_valid || out_ready) && !w_hazard;
    assign w_accept  = in_valid && in_ready;
    assign w_hit1    = wb_en && wb_rd != 5'd0 && wb_rd == r_rs1_idx;
    assign w_hit2    = wb_en && wb_rd != 5'd0 && wb_rd == r_rs2_idx;

    reg_file #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS)) u_rf (
        .clk      (clk),
        .rst_n    (reset),
        .i_we     (wb_en),
        .i_waddr  (wb_rd),
        .i_wdata  (wb_data),
        .i_raddr1 (w_rs1_idx),
        .i_raddr2 (w_rs2_idx),
        .o_rdata1 (w_rs1_data),
        .o_rdata2 (w_rs2_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            rs1_data     <= '0;
            rs2_data     <= '0;
            imm_out      <= '0;
            pc_out       <= '0;
            rd_out       <= '0;
            opcode_out_d <= '0;
            fn3_out_d    <= '0;
            fn7_5        <= 1'b0;
            branch       <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            alu_src      <= 1'b0;
            reg_write    <= 1'b0;
            illegal      <= 1'b0;
            memtoreg     <= '0;
            aluop        <= '0;
            r_rs1_idx    <= '0;
            r_rs2_idx    <= '0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (w_accept)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
            if (w_accept) begin
                rs1_data     <= w_rs1_data;
                rs2_data     <= w_rs2_data;
                imm_out      <= w_imm;
                pc_out       <= pc_in;
                rd_out       <= instruction[11:7];
                opcode_out_d <= instruction[6:0];
                fn3_out_d    <= instruction[14:12];
                fn7_5        <= instruction[30];
                branch       <= w_ctrl.branch;
                mem_read     <= w_ctrl.mem_read;
                mem_write    <= w_ctrl.mem_write;
                alu_src      <= w_ctrl.alu_src;
                reg_write    <= w_ctrl.reg_write;
                illegal      <= w_ctrl.illegal;
                memtoreg     <= w_ctrl.memtoreg;
                aluop        <= w_ctrl.aluop;
                r_rs1_idx    <= w_rs1_idx;
                r_rs2_idx    <= w_rs2_idx;
            end else if (out_valid && !out_ready) begin
                if (w_hit1) rs1_data <= wb_data;
                if (w_hit2) rs2_data <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed scenario tests for id_stage_pipe, with a second
// BYPASS=0 instance sharing stimulus to contrast same-cycle read behaviour.
module tb_id_stage_pipe;
    logic        clk = 1'b0, reset = 1'b0;
    logic        in_valid = 1'b0, wb_en = 1'b0, ex_mem_read = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] instruction = '0, pc_in = '0, wb_data = '0;
    logic [4:0]  wb_rd = '0, ex_rd = '0;
    logic        in_ready, out_valid, fn7_5, branch, mem_read, mem_write, alu_src, reg_write, illegal;
    logic [31:0] rs1_data, rs2_data, imm_out, pc_out;
    logic [4:0]  rd_out;
    logic [6:0]  opcode_out_d;
    logic [2:0]  fn3_out_d, aluop;
    logic [1:0]  memtoreg;
    logic        nb_in_ready, nb_out_valid, nb_fn7_5, nb_branch, nb_mem_read, nb_mem_write, nb_alu_src, nb_reg_write, nb_illegal;
    logic [31:0] nb_rs1_data, nb_rs2_data, nb_imm_out, nb_pc_out;
    logic [4:0]  nb_rd_out;
    logic [6:0]  nb_opcode_out_d;
    logic [2:0]  nb_fn3_out_d, nb_aluop;
    logic [1:0]  nb_memtoreg;
    int n_cmp = 0, n_err = 0;

    localparam logic [31:0] I_ADD_3_1_2  = 32'h002081B3;
    localparam logic [31:0] I_ANDI_10_3  = 32'hFFF1F513;
    localparam logic [31:0] I_BEQ_1_2_8  = 32'h00208463;
    localparam logic [31:0] I_ADD_6_4_5  = 32'h00520333;
    localparam logic [31:0] I_ADDI_8_5_0 = 32'h00028413;
    localparam logic [31:0] I_ADD_8_6_7  = 32'h00730433;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
        .pc_in(pc_in), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .imm_out(imm_out), .pc_out(pc_out), .rd_out(rd_out), .opcode_out_d(opcode_out_d),
        .fn3_out_d(fn3_out_d), .fn7_5(fn7_5), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src(alu_src), .reg_write(reg_write), .illegal(illegal), .memtoreg(memtoreg), .aluop(aluop)
    );

    id_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nb_in_ready), .instruction(instruction),
        .pc_in(pc_in), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .flush(flush), .out_valid(nb_out_valid), .out_ready(out_ready), .rs1_data(nb_rs1_data),
        .rs2_data(nb_rs2_data), .imm_out(nb_imm_out), .pc_out(nb_pc_out), .rd_out(nb_rd_out),
        .opcode_out_d(nb_opcode_out_d), .fn3_out_d(nb_fn3_out_d), .fn7_5(nb_fn7_5), .branch(nb_branch),
        .mem_read(nb_mem_read), .mem_write(nb_mem_write), .alu_src(nb_alu_src), .reg_write(nb_reg_write),
        .illegal(nb_illegal), .memtoreg(nb_memtoreg), .aluop(nb_aluop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        wb_en = 1'b1; wb_rd = rd; wb_data = data;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (rs1_data !== 32'h0) begin n_err++; $display("FAIL rst_rs1: got %h want 0", rs1_data); end
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_add();
        wb_write(5'd1, 32'h11110000);
        wb_write(5'd2, 32'h22220000);
        out_ready = 1'b1; in_valid = 1'b1; instruction = I_ADD_3_1_2; pc_in = 32'h100;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_in_ready: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %0b want 1", out_valid); end
        n_cmp++; if (rs1_data !== 32'h11110000) begin n_err++; $display("FAIL add_rs1: got %h want 11110000", rs1_data); end
        n_cmp++; if (rs2_data !== 32'h22220000) begin n_err++; $display("FAIL add_rs2: got %h want 22220000", rs2_data); end
        n_cmp++; if (aluop !== 3'b010) begin n_err++; $display("FAIL add_aluop: got %b want 010", aluop); end
        n_cmp++; if (reg_write !== 1'b1) begin n_err++; $display("FAIL add_reg_write: got %0b want 1", reg_write); end
        n_cmp++; if (rd_out !== 5'd3) begin n_err++; $display("FAIL add_rd: got %0d want 3", rd_out); end
        n_cmp++; if (pc_out !== 32'h100) begin n_err++; $display("FAIL add_pc: got %h want 100", pc_out); end
        n_cmp++; if (imm_out !== 32'h0) begin n_err++; $display("FAIL add_imm: got %h want 0", imm_out); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_valid: got %0b want 0", out_valid); end
    endtask

    task automatic test_imm();
        in_valid = 1'b1; instruction = I_ANDI_10_3;
        tick();
        n_cmp++; if (imm_out !== 32'hFFFFFFFF) begin n_err++; $display("FAIL andi_imm: got %h want ffffffff", imm_out); end
        n_cmp++; if (aluop !== 3'b011 || alu_src !== 1'b1) begin n_err++; $display("FAIL andi_ctrl: got aluop=%b alu_src=%0b want 011/1", aluop, alu_src); end
        n_cmp++; if (fn3_out_d !== 3'b111) begin n_err++; $display("FAIL andi_fn3: got %b want 111", fn3_out_d); end
        instruction = I_BEQ_1_2_8;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (imm_out !== 32'd8) begin n_err++; $display("FAIL beq_imm: got %h want 8", imm_out); end
        n_cmp++; if (branch !== 1'b1 || aluop !== 3'b001 || reg_write !== 1'b0) begin n_err++; $display("FAIL beq_ctrl: got br=%0b aluop=%b rw=%0b want 1/001/0", branch, aluop, reg_write); end
    endtask

    task automatic test_hazard();
        ex_mem_read = 1'b1; ex_rd = 5'd7; in_valid = 1'b1; instruction = I_ADD_6_4_5;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL haz_unrelated: got %0b want 1", in_ready); end
        ex_rd = 5'd4;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL haz_stall: got %0b want 0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL haz_bubble: got %0b want 0", out_valid); end
        ex_mem_read = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL haz_release: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || rd_out !== 5'd6) begin n_err++; $display("FAIL haz_accept: got v=%0b rd=%0d want 1/6", out_valid, rd_out); end
    endtask

    task automatic test_bypass();
        wb_write(5'd5, 32'h00000055);
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hCAFEBABE; in_valid = 1'b1; instruction = I_ADDI_8_5_0;
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        n_cmp++; if (rs1_data !== 32'hCAFEBABE) begin n_err++; $display("FAIL bypass1_rs1: got %h want cafebabe", rs1_data); end
        n_cmp++; if (nb_rs1_data !== 32'h00000055) begin n_err++; $display("FAIL bypass0_rs1: got %h want 00000055", nb_rs1_data); end
    endtask

    task automatic test_hold_flush();
        wb_write(5'd7, 32'h00000077);
        out_ready = 1'b0; in_valid = 1'b1; instruction = I_ADD_8_6_7;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || rs2_data !== 32'h77) begin n_err++; $display("FAIL hold_load: got v=%0b rs2=%h want 1/77", out_valid, rs2_data); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready: got %0b want 0", in_ready); end
        wb_write(5'd7, 32'hDEADBEEF);
        n_cmp++; if (rs2_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL hold_track: got %h want deadbeef", rs2_data); end
        n_cmp++; if (out_valid !== 1'b1 || rd_out !== 5'd8) begin n_err++; $display("FAIL hold_keep: got v=%0b rd=%0d want 1/8", out_valid, rd_out); end
        flush = 1'b1; in_valid = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %0b want 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1; in_valid = 1'b1; instruction = 32'hFFFFFFFF;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (illegal !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL ill_flag: got ill=%0b v=%0b want 1/1", illegal, out_valid); end
        n_cmp++; if (reg_write !== 1'b0 || mem_write !== 1'b0 || mem_read !== 1'b0 || branch !== 1'b0) begin n_err++; $display("FAIL ill_ctrl: got rw=%0b mw=%0b mr=%0b br=%0b want 0", reg_write, mem_write, mem_read, branch); end
        n_cmp++; if (imm_out !== 32'h0) begin n_err++; $display("FAIL ill_imm: got %h want 0", imm_out); end
    endtask

    task automatic test_reset_mid_stall();
        tick();
        out_ready = 1'b0; in_valid = 1'b1; instruction = I_ADD_3_1_2;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || rs1_data !== 32'h11110000) begin n_err++; $display("FAIL stall_pre: got v=%0b rs1=%h want 1/11110000", out_valid, rs1_data); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL arst_clear: got v=%0b rdy=%0b want 0/0", out_valid, in_ready); end
        n_cmp++; if (rs1_data !== 32'h0 || reg_write !== 1'b0) begin n_err++; $display("FAIL arst_data: got rs1=%h rw=%0b want 0/0", rs1_data, reg_write); end
        tick();
        reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1; instruction = I_ADD_3_1_2;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || rs1_data !== 32'h0 || rs2_data !== 32'h0) begin n_err++; $display("FAIL arst_regs: got v=%0b rs1=%h rs2=%h want 1/0/0", out_valid, rs1_data, rs2_data); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_hazard();
        test_bypass();
        test_hold_flush();
        test_illegal();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
